// File: rtl/scic_pkg.sv
// rtl/scic_pkg.sv - shared widths, I/O address map and STATUS bit layout for the responder
// Purpose: constants shared by scic_mem_responder, scic_tx_fifo and their bench.
// Ports: none (package).
package scic_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;

  localparam logic [ADDR_W-1:0] IO_BASE     = 16'hFF00;
  localparam logic [ADDR_W-1:0] GPIO_ADDR   = IO_BASE + 16'd0;
  localparam logic [ADDR_W-1:0] TXPUSH_ADDR = IO_BASE + 16'd1;
  localparam logic [ADDR_W-1:0] STATUS_ADDR = IO_BASE + 16'd2;
  localparam logic [ADDR_W-1:0] TCOUNT_ADDR = IO_BASE + 16'd3;
  localparam logic [ADDR_W-1:0] TCMP_ADDR   = IO_BASE + 16'd4;
  localparam logic [ADDR_W-1:0] TFLAG_ADDR  = IO_BASE + 16'd5;

  localparam int ST_EMPTY_BIT    = 0;
  localparam int ST_FULL_BIT     = 1;
  localparam int ST_COUNT_LSB    = 2;
  localparam int ST_COUNT_MSB    = 5;
  localparam int ST_OVERFLOW_BIT = 6;

endpackage

// File: rtl/scic_tx_fifo.sv
// rtl/scic_tx_fifo.sv - synchronous TX FIFO with sticky overflow and show-ahead head output
// Purpose: holds words pushed by the CPU until the downstream sink takes them.
// Ports:
//   clock, reset           - clock, asynchronous active-high reset
//   push, push_data        - push request and word
//   pop                    - pop request (caller qualifies with non-empty)
//   clear_overflow         - clears the sticky overflow flag
//   head                   - oldest entry, 0 when empty
//   full, empty, count     - occupancy
//   overflow               - sticky: a push was dropped because the FIFO was full
module scic_tx_fifo
  import scic_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     clear_overflow,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A push into a full FIFO still lands when a pop frees a slot on the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Head is forced to 0 when empty so reset/drain never exposes stale storage.
  assign head = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      // Pointers are PW bits wide, so the increment wraps modulo DEPTH.
      if (push_ok) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/scic_mem_responder.sv
// rtl/scic_mem_responder.sv - zero-wait-state CPU memory responder: RAM, GPIO, TX FIFO, optional timer
// Purpose: decodes the CPU bus into RAM (0..DEPTH-1) and I/O registers at 0xFF00..0xFF05.
//   Optional feature macro SCIC_TIMER_EN adds TCOUNT/TCMP/TFLAG; without it those
//   addresses read 0 and ignore writes.
// Ports:
//   clock, reset         - clock, asynchronous active-high reset
//   address, data_in, we - CPU bus request (write commits on the rising edge)
//   data_out             - combinational read data for the current address
//   gpio_out             - GPIO register
//   tx_data, tx_valid    - TX FIFO head and non-empty
//   tx_ready             - downstream accepts tx_data
module scic_mem_responder
  import scic_pkg::*;
#(
  parameter int DEPTH      = 4096,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  input  logic              we,
  output logic [DATA_W-1:0] data_out,
  output logic [DATA_W-1:0] gpio_out,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_W-1:0] ram [DEPTH];
  logic              in_ram;
  logic [DATA_W-1:0] gpio;
  logic [DATA_W-1:0] status;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_overflow;
  logic              clear_overflow;
  logic [CW-1:0]     fifo_count;

  // RAM occupies the bottom DEPTH words; everything above is I/O or unmapped.
  assign in_ram = ((address >> AW) == '0);

  assign fifo_push      = we && (address == TXPUSH_ADDR);
  assign clear_overflow = we && (address == STATUS_ADDR);
  assign fifo_pop       = tx_valid && tx_ready;
  assign tx_valid       = !fifo_empty;
  assign gpio_out       = gpio;

  always_ff @(posedge clock) begin
    if (we && in_ram) begin
      ram[address[AW-1:0]] <= data_in;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      gpio <= '0;
    end else if (we && (address == GPIO_ADDR)) begin
      gpio <= data_in;
    end
  end

  scic_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clock          (clock),
    .reset          (reset),
    .push           (fifo_push),
    .push_data      (data_in),
    .pop            (fifo_pop),
    .clear_overflow (clear_overflow),
    .head           (tx_data),
    .full           (fifo_full),
    .empty          (fifo_empty),
    .count          (fifo_count),
    .overflow       (fifo_overflow)
  );

`ifdef SCIC_TIMER_EN
  logic [DATA_W-1:0] tcount;
  logic [DATA_W-1:0] tcmp;
  logic              tflag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tcount <= '0;
      tcmp   <= '1;
      tflag  <= 1'b0;
    end else begin
      tcount <= (we && (address == TCOUNT_ADDR)) ? data_in : tcount + 32'd1;
      if (we && (address == TCMP_ADDR)) begin
        tcmp <= data_in;
      end
      // Match is taken on the pre-increment count and beats a same-cycle W1C.
      if (tcount == tcmp) begin
        tflag <= 1'b1;
      end else if (we && (address == TFLAG_ADDR) && data_in[0]) begin
        tflag <= 1'b0;
      end
    end
  end
`endif

  always_comb begin
    status                              = '0;
    status[ST_EMPTY_BIT]                = fifo_empty;
    status[ST_FULL_BIT]                 = fifo_full;
    status[ST_COUNT_MSB:ST_COUNT_LSB]   = 4'(fifo_count);
    status[ST_OVERFLOW_BIT]             = fifo_overflow;
  end

  always_comb begin
    data_out = '0;
    if (in_ram) begin
      data_out = ram[address[AW-1:0]];
    end else begin
      case (address)
        GPIO_ADDR:   data_out = gpio;
        STATUS_ADDR: data_out = status;
`ifdef SCIC_TIMER_EN
        TCOUNT_ADDR: data_out = tcount;
        TCMP_ADDR:   data_out = tcmp;
        TFLAG_ADDR:  data_out = {31'd0, tflag};
`endif
        default:     data_out = '0;
      endcase
    end
  end

endmodule
